// File: rtl/store_queue_pkg.sv
// Shared types for the store queue: store-size encodings, the queued entry layout
// and the base byte-strobe pattern for each size.
package store_queue_pkg;

    localparam logic [1:0] SPL_SB = 2'b00;
    localparam logic [1:0] SPL_SH = 2'b01;
    localparam logic [1:0] SPL_SW = 2'b10;
    localparam logic [1:0] SPL_SD = 2'b11;

    typedef struct packed {
        logic [60:0] dw_addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } store_entry_t;

    // Strobe pattern for a store sitting at byte offset 0 of its doubleword.
    function automatic logic [7:0] base_strb(input logic [1:0] size);
        logic [7:0] strb;
        case (size)
            SPL_SB:  strb = 8'h01;
            SPL_SH:  strb = 8'h03;
            SPL_SW:  strb = 8'h0F;
            SPL_SD:  strb = 8'hFF;
            default: strb = 8'h00;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/store_queue_align.sv
// Combinational store lane steering: natural-alignment check, data shift into the
// addressed byte lane, and write-strobe generation.
module store_align
    import store_queue_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] data_i,
    output logic        misaligned_o,
    output logic [63:0] wdata_o,
    output logic [7:0]  wstrb_o
);

    // Alignment violation depends only on the low offset bits the size cares about.
    always_comb begin
        misaligned_o = 1'b0;
        case (size_i)
            SPL_SB:  misaligned_o = 1'b0;
            SPL_SH:  misaligned_o = off_i[0];
            SPL_SW:  misaligned_o = |off_i[1:0];
            SPL_SD:  misaligned_o = |off_i;
            default: misaligned_o = 1'b1;
        endcase
    end

    // Shift data and strobe up to the addressed byte; overflow bits fall off the top.
    always_comb begin
        wdata_o = data_i << {off_i, 3'b000};
        wstrb_o = base_strb(size_i) << off_i;
    end

endmodule

// File: rtl/store_queue.sv
// Committed-store FIFO between the MEM-stage splicer and data memory, with
// req/ack drain and doubleword-granular load conflict detection.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_st_valid,
    output logic                       o_st_ready,
    input  logic [1:0]                 i_st_size,
    input  logic [63:0]                i_st_addr,
    input  logic [63:0]                i_st_data,
    output logic                       o_misaligned,
    input  logic                       i_ld_valid,
    input  logic [63:0]                i_ld_addr,
    output logic                       o_ld_conflict,
    output logic                       o_mem_req,
    input  logic                       i_mem_ack,
    output logic [63:0]                o_mem_addr,
    output logic [63:0]                o_mem_wdata,
    output logic [7:0]                 o_mem_wstrb,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    store_entry_t   entries_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;

    logic           viol_s;
    logic [63:0]    lane_data_s;
    logic [7:0]     lane_strb_s;
    logic           full_s;
    logic           empty_s;
    logic           enq_s;
    logic           deq_s;
    logic           hit_s;
    store_entry_t   head_s;
    store_entry_t   new_entry_s;
    logic           unused_ld_off_s;

    store_align u_align (
        .size_i       (i_st_size),
        .off_i        (i_st_addr[2:0]),
        .data_i       (i_st_data),
        .misaligned_o (viol_s),
        .wdata_o      (lane_data_s),
        .wstrb_o      (lane_strb_s)
    );

    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);

    assign o_misaligned = i_st_valid & viol_s;
    assign o_st_ready   = ~rst & ~full_s;
    assign enq_s        = i_st_valid & o_st_ready & ~viol_s;
    assign o_mem_req    = ~empty_s;
    assign deq_s        = o_mem_req & i_mem_ack;

    assign new_entry_s = '{dw_addr: i_st_addr[63:3], data: lane_data_s, strb: lane_strb_s};
    assign head_s      = entries_q[rd_ptr_q[AW-1:0]];
    assign o_mem_addr  = {head_s.dw_addr, 3'b000};
    assign o_mem_wdata = head_s.data;
    assign o_mem_wstrb = head_s.strb;
    assign o_empty     = empty_s;
    assign o_count     = wr_ptr_q - rd_ptr_q;

    assign unused_ld_off_s = ^i_ld_addr[2:0];

    // Pointer and valid-bit next state; enqueue and dequeue never touch the same slot.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (deq_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            valid_d[rd_ptr_q[AW-1:0]] = 1'b0;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (enq_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            valid_d[wr_ptr_q[AW-1:0]] = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Conservative doubleword match against every occupied slot, head included.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = hit_s | (valid_q[i] & (entries_q[i].dw_addr == i_ld_addr[63:3]));
        end
        o_ld_conflict = i_ld_valid & hit_s;
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            valid_q  <= {DEPTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage is only meaningful under its valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            entries_q[wr_ptr_q[AW-1:0]] <= new_entry_s;
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: stimulus pushes expected memory writes into a
// scoreboard, and a monitor pops and compares them as the DUT retires its head.
module tb_store_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_st_valid = 1'b0;
    logic        o_st_ready;
    logic [1:0]  i_st_size = 2'b00;
    logic [63:0] i_st_addr = 64'h0;
    logic [63:0] i_st_data = 64'h0;
    logic        o_misaligned;
    logic        i_ld_valid = 1'b0;
    logic [63:0] i_ld_addr = 64'h0;
    logic        o_ld_conflict;
    logic        o_mem_req;
    logic        i_mem_ack = 1'b0;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wstrb;
    logic        o_empty;
    logic [2:0]  o_count;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } wr_t;

    wr_t exp_q[$];
    int  pass_cnt = 0;
    int  total_cnt = 0;

    store_queue #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_st_valid    (i_st_valid),
        .o_st_ready    (o_st_ready),
        .i_st_size     (i_st_size),
        .i_st_addr     (i_st_addr),
        .i_st_data     (i_st_data),
        .o_misaligned  (o_misaligned),
        .i_ld_valid    (i_ld_valid),
        .i_ld_addr     (i_ld_addr),
        .o_ld_conflict (o_ld_conflict),
        .o_mem_req     (o_mem_req),
        .i_mem_ack     (i_mem_ack),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .o_mem_wstrb   (o_mem_wstrb),
        .o_empty       (o_empty),
        .o_count       (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] size, input logic [63:0] addr, input logic [63:0] data);
        i_st_valid = 1'b1;
        i_st_size  = size;
        i_st_addr  = addr;
        i_st_data  = data;
    endtask

    task automatic expect_wr(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
        wr_t w;
        w.addr = addr;
        w.data = data;
        w.strb = strb;
        exp_q.push_back(w);
    endtask

    // Monitor: a head write retires at the coming edge whenever req and ack are both high.
    always @(negedge clk) begin
        if (!rst && o_mem_req && i_mem_ack) begin
            wr_t w;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL mem_write: unexpected addr %h data %h strb %h", o_mem_addr, o_mem_wdata, o_mem_wstrb);
            end else begin
                w = exp_q.pop_front();
                if (o_mem_addr === w.addr && o_mem_wdata === w.data && o_mem_wstrb === w.strb) pass_cnt++;
                else $display("FAIL mem_write: got %h/%h/%h expected %h/%h/%h",
                              o_mem_addr, o_mem_wdata, o_mem_wstrb, w.addr, w.data, w.strb);
            end
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_ready", o_st_ready, 0);
        chk("rst_count", o_count, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_req", o_mem_req, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", o_st_ready, 1);

        // 1: SB lane shift and strobe
        tick();
        offer(2'b00, 64'h1005, 64'hAB);
        @(negedge clk);
        chk("sb_misaligned", o_misaligned, 0);
        chk("sb_req_before", o_mem_req, 0);
        tick();
        expect_wr(64'h1000, 64'h0000AB0000000000, 8'h20);
        i_st_valid = 1'b0;
        @(negedge clk);
        chk("sb_req_after", o_mem_req, 1);
        chk("sb_count", o_count, 1);
        tick();
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        @(negedge clk);
        chk("sb_empty", o_empty, 1);

        // 2: misaligned SW never enqueued
        tick();
        offer(2'b10, 64'h2002, 64'hDEADBEEF);
        @(negedge clk);
        chk("sw_misaligned", o_misaligned, 1);
        chk("sw_ready", o_st_ready, 1);
        tick();
        i_st_valid = 1'b0;
        @(negedge clk);
        chk("sw_count", o_count, 0);
        chk("sw_req", o_mem_req, 0);

        // 3: fill to DEPTH, full rejects even with same-cycle ack, drain in order
        for (int k = 0; k < 4; k++) begin
            tick();
            offer(2'b11, 64'h4000 + 64'(8 * k), 64'hA0A0_0000_0000_0000 + 64'(k));
            @(posedge clk);
            expect_wr(64'h4000 + 64'(8 * k), 64'hA0A0_0000_0000_0000 + 64'(k), 8'hFF);
            #1;
            i_st_valid = 1'b0;
        end
        @(negedge clk);
        chk("full_ready", o_st_ready, 0);
        chk("full_count", o_count, 4);
        tick();
        offer(2'b11, 64'h4020, 64'hBAD);
        i_mem_ack = 1'b1;
        @(negedge clk);
        chk("full_ready_ack", o_st_ready, 0);
        tick();
        i_st_valid = 1'b0;
        @(negedge clk);
        chk("full_after_deq", o_count, 3);
        repeat (3) tick();
        i_mem_ack = 1'b0;
        @(negedge clk);
        chk("full_drained", o_empty, 1);
        chk("full_drained_cnt", o_count, 0);

        // 4: load conflict at doubleword granularity
        tick();
        offer(2'b01, 64'h3006, 64'h1234);
        tick();
        expect_wr(64'h3000, 64'h1234_0000_0000_0000, 8'hC0);
        i_st_valid = 1'b0;
        i_ld_valid = 1'b1;
        i_ld_addr  = 64'h3000;
        @(negedge clk);
        chk("ld_hit", o_ld_conflict, 1);
        tick();
        i_ld_addr = 64'h3008;
        @(negedge clk);
        chk("ld_miss", o_ld_conflict, 0);
        tick();
        i_ld_valid = 1'b0;
        i_ld_addr  = 64'h3000;
        @(negedge clk);
        chk("ld_not_valid", o_ld_conflict, 0);
        tick();
        i_mem_ack = 1'b1;
        tick();
        i_mem_ack = 1'b0;

        // 5: steady enqueue+dequeue, count stays 1 through pointer wrap
        offer(2'b11, 64'h5000, 64'hC0DE_0000_0000_0000);
        tick();
        expect_wr(64'h5000, 64'hC0DE_0000_0000_0000, 8'hFF);
        for (int k = 1; k < 10; k++) begin
            offer(2'b11, 64'h5000 + 64'(8 * k), 64'hC0DE_0000_0000_0000 + 64'(k));
            i_mem_ack = 1'b1;
            @(negedge clk);
            chk("steady_count", o_count, 1);
            tick();
            expect_wr(64'h5000 + 64'(8 * k), 64'hC0DE_0000_0000_0000 + 64'(k), 8'hFF);
        end
        i_st_valid = 1'b0;
        tick();
        i_mem_ack = 1'b0;
        @(negedge clk);
        chk("steady_empty", o_empty, 1);

        // 6: reset with req high and three entries queued abandons them
        for (int k = 0; k < 3; k++) begin
            tick();
            offer(2'b11, 64'h6000 + 64'(8 * k), 64'(k));
        end
        tick();
        i_st_valid = 1'b0;
        i_ld_valid = 1'b1;
        i_ld_addr  = 64'h6000;
        @(negedge clk);
        chk("pre_rst_count", o_count, 3);
        chk("pre_rst_req", o_mem_req, 1);
        chk("pre_rst_conflict", o_ld_conflict, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_req", o_mem_req, 0);
        chk("in_rst_count", o_count, 0);
        chk("in_rst_ready", o_st_ready, 0);
        chk("in_rst_conflict", o_ld_conflict, 0);
        tick();
        @(negedge clk);
        chk("in_rst_ready2", o_st_ready, 0);
        tick();
        rst = 1'b0;
        i_ld_valid = 1'b0;
        @(negedge clk);
        chk("out_rst_ready", o_st_ready, 1);
        chk("out_rst_req", o_mem_req, 0);
        chk("out_rst_count", o_count, 0);

        chk("scoreboard_left", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
